// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: forwarding selects and the
// divider-busy FSM state encoding.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_E  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/hazard_ctrl_mc_div_stall_fsm.sv
// Divider-busy tracker: stalls for DIV_LAT cycles starting with the issue
// cycle, then spends one non-stalling DONE cycle while the result is consumed.
module div_stall_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic stall
);

  localparam int CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // State and countdown registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; the issue cycle is the first stall cycle, so BUSY lasts DIV_LAT-1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_d   = CNT_LOAD;
            state_d = (DIV_LAT == 1) ? DONE : BUSY;
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign stall = (state_q == BUSY) | ((state_q == IDLE) & start);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage core: forwarding selects, prioritised
// stall/flush generation, divider-busy tracking and a stall-cycle counter.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [RA_W-1:0] rsD,
  input  logic [RA_W-1:0] rtD,
  input  logic            branchD,
  input  logic            jumpD,
  input  logic [RA_W-1:0] rsE,
  input  logic [RA_W-1:0] rtE,
  input  logic [RA_W-1:0] writeregE,
  input  logic            regwriteE,
  input  logic            memtoregE,
  input  logic            div_startE,
  input  logic [RA_W-1:0] writeregM,
  input  logic            regwriteM,
  input  logic            memtoregM,
  input  logic            memreqM,
  input  logic            dmem_readyM,
  input  logic            excM,
  input  logic [RA_W-1:0] writeregW,
  input  logic            regwriteW,
  output logic [1:0]      forwardaD,
  output logic [1:0]      forwardbD,
  output logic [1:0]      forwardaE,
  output logic [1:0]      forwardbE,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            stallM,
  output logic            stallW,
  output logic            flushF,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic            flushW,
  output logic            div_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [RA_W-1:0]  ZERO_REG = {RA_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             loadstall_s, brstall_s, memwait_s, divstall_s;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // M-stage producer beats the older alternative; r0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                         input logic [RA_W-1:0] reg_m, input logic we_m,
                                         input logic [RA_W-1:0] reg_o, input logic we_o,
                                         input logic [1:0] sel_o);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src == ZERO_REG)                 sel = FWD_RF;
    else if (we_m && (reg_m == src))     sel = FWD_M;
    else if (we_o && (reg_o == src))     sel = sel_o;
    else                                 sel = FWD_RF;
    return sel;
  endfunction

  assign forwardaD = resetn ? fwd_sel(rsD, writeregM, regwriteM, writeregE, regwriteE, FWD_E) : FWD_RF;
  assign forwardbD = resetn ? fwd_sel(rtD, writeregM, regwriteM, writeregE, regwriteE, FWD_E) : FWD_RF;
  assign forwardaE = resetn ? fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW, FWD_W) : FWD_RF;
  assign forwardbE = resetn ? fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW, FWD_W) : FWD_RF;

  assign loadstall_s = memtoregE & (writeregE != ZERO_REG) &
                       ((writeregE == rsD) | (writeregE == rtD));
  assign brstall_s   = (branchD | jumpD) &
                       ((regwriteE & (writeregE != ZERO_REG) & ((writeregE == rsD) | (writeregE == rtD))) |
                        (memtoregM & (writeregM != ZERO_REG) & ((writeregM == rsD) | (writeregM == rtD))));
  assign memwait_s   = memreqM & ~dmem_readyM;

  div_stall_fsm #(.DIV_LAT(DIV_LAT)) u_div (
    .clk   (clk),
    .resetn(resetn),
    .start (div_startE),
    .abort (excM),
    .busy  (div_busy),
    .stall (divstall_s)
  );

  // Priority encoder; each branch stalls a prefix of the pipe and bubbles the stage after it.
  always_comb begin
    {stallF, stallD, stallE, stallM, stallW} = 5'b00000;
    {flushF, flushD, flushE, flushM, flushW} = 5'b00000;
    if (!resetn) begin
      stallF = 1'b0;
    end else if (excM) begin
      {flushF, flushD, flushE, flushM} = 4'b1111;
    end else if (memwait_s) begin
      {stallF, stallD, stallE, stallM} = 4'b1111;
      flushW = 1'b1;
    end else if (divstall_s) begin
      {stallF, stallD, stallE} = 3'b111;
      flushM = 1'b1;
    end else if (brstall_s | loadstall_s) begin
      {stallF, stallD} = 2'b11;
      flushE = 1'b1;
    end else begin
      stallF = 1'b0;
    end
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallF && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc: behavioural reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_hazard_ctrl_mc;

  localparam int RA_W    = 5;
  localparam int DIV_LAT = 4;
  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic resetn;
  logic [RA_W-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic branchD, jumpD, regwriteE, memtoregE, div_startE;
  logic regwriteM, memtoregM, memreqM, dmem_readyM, excM, regwriteW;
  logic [1:0] forwardaD, forwardbD, forwardaE, forwardbE;
  logic stallF, stallD, stallE, stallM, stallW;
  logic flushF, flushD, flushE, flushM, flushW;
  logic div_busy;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: remaining BUSY cycles, pending DONE cycle, stall tally.
  int busy_left = 0;
  bit done_pend = 1'b0;
  int stall_cnt = 0;
  int base_cnt;

  hazard_ctrl_mc #(.RA_W(RA_W), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpD(jumpD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE), .memtoregE(memtoregE),
    .div_startE(div_startE), .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .memreqM(memreqM), .dmem_readyM(dmem_readyM), .excM(excM), .writeregW(writeregW),
    .regwriteW(regwriteW), .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE),
    .forwardbE(forwardbE), .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .stallW(stallW), .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .flushW(flushW), .div_busy(div_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [RA_W-1:0] s,
                                         input logic [RA_W-1:0] rm, input logic wm,
                                         input logic [RA_W-1:0] ro, input logic wo,
                                         input logic [1:0] code_o);
    if (s == 0)             return 2'b00;
    if (wm && rm == s)      return 2'b10;
    if (wo && ro == s)      return code_o;
    return 2'b00;
  endfunction

  // Compare process: check every cycle on the falling edge, then advance the model.
  always @(negedge clk) begin
    logic [9:0] exp_v, act_v;
    bit ld, br, mw, dv;
    ld = memtoregE && writeregE != 0 && (writeregE == rsD || writeregE == rtD);
    br = (branchD || jumpD) &&
         ((regwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)) ||
          (memtoregM && writeregM != 0 && (writeregM == rsD || writeregM == rtD)));
    mw = memreqM && !dmem_readyM;
    dv = (busy_left > 0) || (busy_left == 0 && !done_pend && div_startE);
    if (!resetn) begin
      busy_left = 0; done_pend = 1'b0; stall_cnt = 0;
    end
    if (!resetn)   exp_v = 10'b00000_00000;
    else if (excM) exp_v = 10'b00000_11110;
    else if (mw)   exp_v = 10'b11110_00001;
    else if (dv)   exp_v = 10'b11100_00010;
    else if (br || ld) exp_v = 10'b11000_00100;
    else           exp_v = 10'b00000_00000;
    act_v = {stallF, stallD, stallE, stallM, stallW, flushF, flushD, flushE, flushM, flushW};
    chk("stall_flush", 32'(act_v), 32'(exp_v));
    chk("fwdaD", 32'(forwardaD), resetn ? 32'(ref_fwd(rsD, writeregM, regwriteM, writeregE, regwriteE, 2'b01)) : 32'd0);
    chk("fwdbD", 32'(forwardbD), resetn ? 32'(ref_fwd(rtD, writeregM, regwriteM, writeregE, regwriteE, 2'b01)) : 32'd0);
    chk("fwdaE", 32'(forwardaE), resetn ? 32'(ref_fwd(rsE, writeregM, regwriteM, writeregW, regwriteW, 2'b01)) : 32'd0);
    chk("fwdbE", 32'(forwardbE), resetn ? 32'(ref_fwd(rtE, writeregM, regwriteM, writeregW, regwriteW, 2'b01)) : 32'd0);
    chk("div_busy", 32'(div_busy), 32'((busy_left > 0) || done_pend));
    chk("stall_cycles", 32'(stall_cycles), 32'(stall_cnt));
    if (resetn) begin
      if (exp_v[9] && stall_cnt < CNT_MAX) stall_cnt++;
      if (excM) begin
        busy_left = 0; done_pend = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) done_pend = 1'b1;
      end else if (done_pend) begin
        done_pend = 1'b0;
      end else if (div_startE) begin
        busy_left = DIV_LAT - 1;
        if (busy_left == 0) done_pend = 1'b1;
      end
    end
  end

  task automatic idle_inputs();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {branchD, jumpD, regwriteE, memtoregE, div_startE} = '0;
    {regwriteM, memtoregM, memreqM, excM, regwriteW} = '0;
    dmem_readyM = 1'b1;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    settle();
    chk("rst_stallF", 32'(stallF), 32'd0);
    chk("rst_busy", 32'(div_busy), 32'd0);
    chk("rst_cnt", 32'(stall_cycles), 32'd0);
    adv(); resetn = 1'b1;

    // Forwarding: M has priority in E; E feeds D alone.
    regwriteE = 1'b1; writeregE = 5'd8; regwriteM = 1'b1; writeregM = 5'd8; rsE = 5'd8;
    settle(); chk("fwdaE_M", 32'(forwardaE), 32'd2);
    adv(); regwriteM = 1'b0; rsD = 5'd8;
    settle(); chk("fwdaD_E", 32'(forwardaD), 32'd1);

    // Load-use: one stall cycle then clear.
    adv(); idle_inputs(); memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd9; rtD = 5'd9;
    settle(); chk("ld_stall", 32'({stallF, stallD, flushE}), 32'h7);
    adv(); idle_inputs();
    settle(); chk("ld_clear", 32'({stallF, stallD, flushE}), 32'h0);
    adv(); memtoregE = 1'b1; writeregE = 5'd0;
    settle(); chk("r0_nostall", 32'(stallF), 32'd0);

    // Divide: four stall cycles, then DONE without stall.
    adv(); idle_inputs(); base_cnt = int'(stall_cycles); div_startE = 1'b1;
    settle(); chk("div_c0", 32'({stallE, flushM}), 32'h3);
    for (int i = 1; i < DIV_LAT; i++) begin
      adv(); div_startE = 1'b0;
      settle(); chk("div_busy_stall", 32'({stallE, div_busy}), 32'h3);
    end
    adv(); settle(); chk("div_done", 32'({stallE, div_busy}), 32'h1);
    chk("div_cnt", 32'(stall_cycles), 32'(base_cnt + 4));
    adv(); settle(); chk("div_idle", 32'(div_busy), 32'd0);

    // Branch stall, then memwait overriding it.
    adv(); branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd3; rsD = 5'd3;
    settle(); chk("br_stall", 32'({stallF, stallD, flushE, stallM}), 32'he);
    adv(); memreqM = 1'b1; dmem_readyM = 1'b0;
    settle(); chk("mw_wins", 32'({stallM, flushE, flushW}), 32'h5);

    // Exception while BUSY with cnt=2 aborts the divide.
    adv(); idle_inputs(); div_startE = 1'b1;
    adv(); div_startE = 1'b0;
    adv(); excM = 1'b1;
    settle(); chk("exc_flush", 32'({flushF, flushD, flushE, flushM, stallF, stallE}), 32'h3c);
    adv(); excM = 1'b0;
    settle(); chk("exc_abort", 32'(div_busy), 32'd0);

    // Async reset mid-BUSY, then a clean restart.
    adv(); div_startE = 1'b1;
    adv(); div_startE = 1'b0;
    adv(); resetn = 1'b0; #1;
    chk("arst_busy", 32'(div_busy), 32'd0);
    chk("arst_stall", 32'({stallF, stallE, flushM}), 32'd0);
    settle(); adv(); resetn = 1'b1; div_startE = 1'b1;
    settle(); chk("restart", 32'(stallE), 32'd1);
    adv(); div_startE = 1'b0;
    for (int i = 0; i < DIV_LAT + 1; i++) adv();

    // Random traffic on a small register set to provoke collisions.
    for (int i = 0; i < 800; i++) begin
      rsD = RA_W'($urandom_range(0, 3)); rtD = RA_W'($urandom_range(0, 3));
      rsE = RA_W'($urandom_range(0, 3)); rtE = RA_W'($urandom_range(0, 3));
      writeregE = RA_W'($urandom_range(0, 3)); writeregM = RA_W'($urandom_range(0, 3));
      writeregW = RA_W'($urandom_range(0, 3));
      regwriteE = 1'($urandom); memtoregE = 1'($urandom_range(0, 3) == 0);
      regwriteM = 1'($urandom); memtoregM = 1'($urandom_range(0, 3) == 0);
      regwriteW = 1'($urandom);
      branchD = 1'($urandom_range(0, 3) == 0); jumpD = 1'($urandom_range(0, 7) == 0);
      memreqM = 1'($urandom); dmem_readyM = 1'($urandom_range(0, 2) != 0);
      div_startE = 1'($urandom_range(0, 9) == 0);
      excM = 1'($urandom_range(0, 29) == 0);
      adv();
    end

    // Hold a memory wait long enough to saturate the counter.
    idle_inputs(); memreqM = 1'b1; dmem_readyM = 1'b0;
    for (int i = 0; i < CNT_MAX + 3; i++) adv();
    settle(); chk("sat_cnt", 32'(stall_cycles), 32'h1f);
    adv(); adv(); settle(); chk("sat_hold", 32'(stall_cycles), 32'h1f);
    adv(); idle_inputs(); settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
